// File: rtl/apple_field.sv
// Multi-apple manager for the snake game: LFSR-driven apple placement, eat detection,
// saturating score and the registered per-pixel apple select for the VGA mixer.
module apple_field #(
  parameter int          NUM_APPLES = 4,
  parameter int          CELL       = 10,
  parameter int          COLS       = 64,
  parameter int          ROWS       = 48,
  parameter int          SCORE_W    = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               VGA_clk,
  input  logic               reset,
  input  logic               start,
  input  logic               frameTick,
  input  logic [9:0]         xCount,
  input  logic [8:0]         yCount,
  input  logic [5:0]         headCol,
  input  logic [5:0]         headRow,
  output logic               apple,
  output logic               score_increment,
  output logic [SCORE_W-1:0] score,
  output logic               spawnBusy
);

  localparam int IDX_W = (NUM_APPLES > 1) ? $clog2(NUM_APPLES) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAW} state_t;

  state_t                  state;
  logic [15:0]             lfsr;
  logic [15:0]             lfsr_next;
  logic                    start_q;
  logic [NUM_APPLES-1:0]   valid;
  logic [NUM_APPLES-1:0]   pending;
  logic [5:0]              slot_col [NUM_APPLES];
  logic [5:0]              slot_row [NUM_APPLES];
  logic [IDX_W-1:0]        cur;
  logic [IDX_W-1:0]        pick_idx;
  logic [NUM_APPLES-1:0]   cur_mask;
  logic [NUM_APPLES-1:0]   eat_mask;
  logic [NUM_APPLES-1:0]   valid_left;
  logic [NUM_APPLES-1:0]   pending_after_eat;
  logic                    more_pending;
  logic [5:0]              cand_col;
  logic [5:0]              cand_row;
  logic                    cand_ok;
  logic [10:0]             x_pix;
  logic [10:0]             y_pix;
  logic [NUM_APPLES-1:0]   hit;

  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign cand_col  = lfsr[5:0];
  assign cand_row  = lfsr[11:6];

  always_comb begin
    eat_mask = '0;
    if (frameTick && start) begin
      for (int i = 0; i < NUM_APPLES; i++) begin
        if (valid[i] && slot_col[i] == headCol && slot_row[i] == headRow)
          eat_mask[i] = 1'b1;
      end
    end
  end

  // A cell freed by an eat this cycle is already available to the candidate check.
  assign valid_left        = valid & ~eat_mask;
  assign pending_after_eat = pending | eat_mask;
  assign cur_mask          = NUM_APPLES'(1) << cur;
  assign more_pending      = |(pending_after_eat & ~cur_mask);

  always_comb begin
    cand_ok = (int'(cand_col) < COLS) && (int'(cand_row) < ROWS) &&
              !(cand_col == headCol && cand_row == headRow);
    for (int i = 0; i < NUM_APPLES; i++) begin
      if (valid_left[i] && slot_col[i] == cand_col && slot_row[i] == cand_row)
        cand_ok = 1'b0;
    end
  end

  always_comb begin
    pick_idx = '0;
    for (int i = NUM_APPLES - 1; i >= 0; i--) begin
      if (pending[i])
        pick_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      state           <= IDLE;
      lfsr            <= LFSR_SEED;
      start_q         <= 1'b0;
      valid           <= '0;
      pending         <= '0;
      cur             <= '0;
      score           <= '0;
      score_increment <= 1'b0;
      spawnBusy       <= 1'b0;
      for (int i = 0; i < NUM_APPLES; i++) begin
        slot_col[i] <= '0;
        slot_row[i] <= '0;
      end
    end else begin
      lfsr            <= lfsr_next;
      start_q         <= start;
      score_increment <= 1'b0;
      if (!start) begin
        valid     <= '0;
        pending   <= '0;
        state     <= IDLE;
        spawnBusy <= 1'b0;
      end else if (!start_q) begin
        score     <= '0;
        valid     <= '0;
        pending   <= '1;
        state     <= SCAN;
        spawnBusy <= 1'b1;
      end else begin
        valid   <= valid_left;
        pending <= pending_after_eat;
        if (|eat_mask) begin
          score_increment <= 1'b1;
          if (score != '1)
            score <= score + 1'b1;
        end
        case (state)
          IDLE: begin
            if (|pending) begin
              state     <= SCAN;
              spawnBusy <= 1'b1;
            end
          end
          SCAN: begin
            if (|pending) begin
              cur   <= pick_idx;
              state <= DRAW;
            end else begin
              state     <= IDLE;
              spawnBusy <= 1'b0;
            end
          end
          DRAW: begin
            if (cand_ok) begin
              slot_col[cur] <= cand_col;
              slot_row[cur] <= cand_row;
              valid         <= valid_left | cur_mask;
              pending       <= pending_after_eat & ~cur_mask;
              state         <= more_pending ? SCAN : IDLE;
              spawnBusy     <= more_pending;
            end
          end
          default: begin
            state     <= IDLE;
            spawnBusy <= 1'b0;
          end
        endcase
      end
    end
  end

  // Cell bounds come from constant multiplies of the stored cell indices.
  assign x_pix = {1'b0, xCount};
  assign y_pix = {2'b00, yCount};

  for (genvar g = 0; g < NUM_APPLES; g++) begin : g_hit
    logic [10:0] x_lo;
    logic [10:0] y_lo;
    assign x_lo   = 11'(slot_col[g]) * 11'(CELL);
    assign y_lo   = 11'(slot_row[g]) * 11'(CELL);
    assign hit[g] = valid[g] &&
                    (x_pix >= x_lo) && (x_pix < x_lo + 11'(CELL)) &&
                    (y_pix >= y_lo) && (y_pix < y_lo + 11'(CELL));
  end

  always_ff @(posedge VGA_clk) begin
    if (reset)
      apple <= 1'b0;
    else
      apple <= start && (|hit);
  end

endmodule

// File: tb/tb_apple_field.sv
// Self-checking bench for apple_field: a cycle-level game model compared every cycle,
// plus directed eat / stop / reset scenarios with literal expectations.
module tb_apple_field;

  localparam int SW        = 2;
  localparam int SCORE_MAX = (1 << SW) - 1;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          start     = 1'b0;
  logic          frameTick = 1'b0;
  logic [9:0]    xCount    = '0;
  logic [8:0]    yCount    = '0;
  logic [5:0]    headCol   = 6'd5;
  logic [5:0]    headRow   = 6'd5;
  logic          apple;
  logic          score_increment;
  logic [SW-1:0] score;
  logic          spawnBusy;

  int checks = 0;
  int errors = 0;
  int exp_score [5] = '{1, 2, 3, 3, 3};

  always #5 clk = ~clk;

  apple_field #(
    .NUM_APPLES(4), .CELL(10), .COLS(64), .ROWS(48), .SCORE_W(SW), .LFSR_SEED(16'hACE1)
  ) dut (
    .VGA_clk(clk), .reset(reset), .start(start), .frameTick(frameTick),
    .xCount(xCount), .yCount(yCount), .headCol(headCol), .headRow(headRow),
    .apple(apple), .score_increment(score_increment), .score(score), .spawnBusy(spawnBusy)
  );

  // Game model: apples as cell coordinates, spawner as "choose slot, then draw until free".
  bit [3:0]    m_valid;
  bit [3:0]    m_pend;
  bit [3:0]    old_pend;
  int          m_col [4];
  int          m_row [4];
  int          m_phase;
  int          m_slot;
  logic [15:0] m_lfsr;
  logic [15:0] draw;
  int          m_score;
  bit          m_inc, m_apple, m_busy, m_run_q;
  bit          model_live = 1'b0;
  int          cand_c, cand_r;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic bit covers(input int c, input int r, input int x, input int y);
    return (x >= c * 10) && (x < c * 10 + 10) && (y >= r * 10) && (y < r * 10 + 10);
  endfunction

  function automatic bit cell_free(input int c, input int r);
    bit ok;
    ok = (c < 64) && (r < 48) && !(c == int'(headCol) && r == int'(headRow));
    for (int i = 0; i < 4; i++)
      if (m_valid[i] && m_col[i] == c && m_row[i] == r) ok = 1'b0;
    return ok;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid = '0; m_pend = '0; m_phase = 0; m_slot = 0; m_lfsr = 16'hACE1;
      m_score = 0; m_inc = 0; m_apple = 0; m_busy = 0; m_run_q = 0; model_live = 1'b1;
      for (int i = 0; i < 4; i++) begin
        m_col[i] = 0;
        m_row[i] = 0;
      end
    end else begin
      draw   = m_lfsr;
      m_lfsr = lfsr_step(m_lfsr);
      m_apple = 1'b0;
      if (start)
        for (int i = 0; i < 4; i++)
          if (m_valid[i] && covers(m_col[i], m_row[i], int'(xCount), int'(yCount))) m_apple = 1'b1;
      m_inc = 1'b0;
      if (!start) begin
        m_valid = '0; m_pend = '0; m_phase = 0;
      end else if (!m_run_q) begin
        m_score = 0; m_valid = '0; m_pend = '1; m_phase = 1;
      end else begin
        old_pend = m_pend;
        for (int i = 0; i < 4; i++) begin
          if (frameTick && m_valid[i] && m_col[i] == int'(headCol) && m_row[i] == int'(headRow)) begin
            m_valid[i] = 1'b0;
            m_pend[i]  = 1'b1;
            m_inc      = 1'b1;
            if (m_score < SCORE_MAX) m_score++;
          end
        end
        if (m_phase == 0) begin
          if (old_pend != 0) m_phase = 1;
        end else if (m_phase == 1) begin
          m_phase = 0;
          for (int i = 3; i >= 0; i--)
            if (old_pend[i]) begin
              m_slot  = i;
              m_phase = 2;
            end
        end else begin
          cand_c = int'(draw[5:0]);
          cand_r = int'(draw[11:6]);
          if (cell_free(cand_c, cand_r)) begin
            m_col[m_slot]   = cand_c;
            m_row[m_slot]   = cand_r;
            m_valid[m_slot] = 1'b1;
            m_pend[m_slot]  = 1'b0;
            m_phase         = (m_pend != 0) ? 1 : 0;
          end
        end
      end
      m_run_q = start;
      m_busy  = (m_phase != 0);
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      check_output("cyc_apple", 32'(apple), 32'(m_apple));
      check_output("cyc_score", 32'(score), 32'(m_score));
      check_output("cyc_score_increment", 32'(score_increment), 32'(m_inc));
      check_output("cyc_spawnBusy", 32'(spawnBusy), 32'(m_busy));
      check_output("cyc_lfsr", 32'(dut.lfsr), 32'(m_lfsr));
    end
  end

  task automatic apply_stimulus(input int x, input int y);
    xCount = 10'(x);
    yCount = 9'(y);
    @(negedge clk);
  endtask

  task automatic wait_busy(input bit level, input int limit, input string name);
    int n = 0;
    while (spawnBusy !== level && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 32'(spawnBusy === level), 32'd1);
  endtask

  task automatic eat(input int s);
    headCol   = 6'(m_col[s]);
    headRow   = 6'(m_row[s]);
    frameTick = 1'b1;
    @(negedge clk);
    frameTick = 1'b0;
  endtask

  task automatic count_apple_pixels(output int cnt);
    bit row_hit;
    cnt = 0;
    for (int y = 0; y < 480; y++) begin
      row_hit = 1'b0;
      for (int i = 0; i < 4; i++)
        if (m_valid[i] && y >= m_row[i] * 10 && y < m_row[i] * 10 + 10) row_hit = 1'b1;
      if (row_hit)
        for (int x = 0; x < 640; x++) begin
          apply_stimulus(x, y);
          if (apple === 1'b1) cnt++;
        end
    end
  endtask

  task automatic coarse_scan();
    for (int y = 0; y < 480; y += 11)
      for (int x = 0; x < 640; x += 13)
        apply_stimulus(x, y);
  endtask

  initial begin
    int old_c, old_r, cnt;
    repeat (3) @(negedge clk);
    check_output("reset_apple", 32'(apple), 32'd0);
    check_output("reset_score", 32'(score), 32'd0);
    check_output("reset_increment", 32'(score_increment), 32'd0);
    check_output("reset_busy", 32'(spawnBusy), 32'd0);
    check_output("reset_lfsr", 32'(dut.lfsr), 32'hACE1);
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check_output("busy_after_start", 32'(spawnBusy), 32'd1);
    wait_busy(1'b0, 200, "initial_spawn_done");
    apply_stimulus(55, 55);
    check_output("no_apple_on_head", 32'(apple), 32'd0);
    count_apple_pixels(cnt);
    check_output("apple_pixel_count", 32'(cnt), 32'd400);

    for (int k = 0; k < 5; k++) begin
      old_c = m_col[k % 4];
      old_r = m_row[k % 4];
      eat(k % 4);
      check_output("eat_pulse", 32'(score_increment), 32'd1);
      check_output("eat_score", 32'(score), 32'(exp_score[k]));
      @(negedge clk);
      check_output("eat_pulse_width", 32'(score_increment), 32'd0);
      repeat (2) @(negedge clk);
      wait_busy(1'b0, 200, "respawn_done");
      if (k == 0) begin
        apply_stimulus(old_c * 10 + 4, old_r * 10 + 4);
        check_output("old_cell_empty", 32'(apple), 32'd0);
        apply_stimulus(m_col[0] * 10, m_row[0] * 10);
        check_output("new_cell_apple", 32'(apple), 32'd1);
      end
    end

    apply_stimulus(m_col[1] * 10 + 2, m_row[1] * 10 + 2);
    eat(2);
    @(negedge clk);
    check_output("busy_in_scan", 32'(spawnBusy), 32'd1);
    @(negedge clk);
    check_output("apple_before_stop", 32'(apple), 32'd1);
    start = 1'b0;
    @(negedge clk);
    check_output("stop_busy", 32'(spawnBusy), 32'd0);
    check_output("stop_apple", 32'(apple), 32'd0);
    repeat (3) @(negedge clk);
    check_output("score_holds_stopped", 32'(score), 32'd3);
    start = 1'b1;
    @(negedge clk);
    check_output("restart_score", 32'(score), 32'd0);
    check_output("restart_busy", 32'(spawnBusy), 32'd1);
    wait_busy(1'b0, 200, "restart_spawn_done");
    coarse_scan();

    apply_stimulus(m_col[1] * 10 + 2, m_row[1] * 10 + 2);
    eat(3);
    @(negedge clk);
    @(negedge clk);
    check_output("apple_before_reset", 32'(apple), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_output("midreset_apple", 32'(apple), 32'd0);
    check_output("midreset_score", 32'(score), 32'd0);
    check_output("midreset_increment", 32'(score_increment), 32'd0);
    check_output("midreset_busy", 32'(spawnBusy), 32'd0);
    check_output("midreset_lfsr", 32'(dut.lfsr), 32'hACE1);
    reset = 1'b0;
    @(negedge clk);
    wait_busy(1'b0, 200, "post_reset_spawn_done");
    coarse_scan();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
